// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns architectural HI/LO,
// runs mult/multu/div/divu over a fixed cycle budget and serves mthi/mtlo.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDA,
    input  logic [31:0] MDB,
    input  logic [2:0]  MDop,
    input  logic        start,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  dbg_state
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;

    logic          start_ok;
    logic          start_div;
    logic          op_signed;
    logic          is_div;
    logic          div_zero;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic [63:0]   product;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    // Handshake: a start strobe with MDop 1..4 and no cancel is accepted only in
    // IDLE; busy is a register that rises the cycle after acceptance and stays
    // high for exactly the op's cycle budget. start is ignored while busy.
    always_comb begin
        start_ok  = start && !cancel &&
                    ((MDop == OP_MULT) || (MDop == OP_MULTU) ||
                     (MDop == OP_DIV)  || (MDop == OP_DIVU));
        start_div = (MDop == OP_DIV) || (MDop == OP_DIVU);
    end

    // Result datapath works on the operands latched at acceptance.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        div_zero  = (b_q == 32'd0);

        mul_a   = {{32{op_signed & a_q[31]}}, a_q};
        mul_b   = {{32{op_signed & b_q[31]}}, b_q};
        product = mul_a * mul_b;

        // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
        abs_a = (op_signed && a_q[31]) ? -a_q : a_q;
        abs_b = (op_signed && b_q[31]) ? -b_q : b_q;
        uq    = div_zero ? 32'd0 : abs_a / abs_b;
        ur    = div_zero ? 32'd0 : abs_a % abs_b;
        quot  = (op_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
        rem   = (op_signed && a_q[31]) ? -ur : ur;

        res_hi = is_div ? rem  : product[63:32];
        res_lo = is_div ? quot : product[31:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        a_q   <= MDA;
                        b_q   <= MDB;
                        op_q  <= MDop;
                        count <= start_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else if (!cancel && (MDop == OP_MTHI)) begin
                        HI <= MDA;
                    end else if (!cancel && (MDop == OP_MTLO)) begin
                        LO <= MDA;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // Divide by zero completes silently with HI/LO untouched.
                            if (!(is_div && div_zero)) begin
                                HI <= res_hi;
                                LO <= res_lo;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    a_busy_tracks_state: assert property (@(posedge clk) disable iff (!reset)
        busy == (state == RUN));
    a_count_live_in_run: assert property (@(posedge clk) disable iff (!reset)
        (state == RUN) |-> (count != '0));

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage pipelined CPU, alongside the single-cycle ALU.
- Takes the same forwarded operand pair as the ALU, runs mult/multu/div/divu over several cycles and holds results in architectural HI/LO.
- Exposes a start/busy handshake that the hazard unit uses to stall the pipeline.
- Also serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MUL_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- MDA  input  32  operand A (rs), forwarded value
- MDB  input  32  operand B (rt), forwarded value
- MDop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others are treated as none
- start  input  1  one-cycle strobe qualifying MDop 1-4
- cancel  input  1  exception/flush from CP0; aborts an in-flight operation
- busy  output  1  operation in progress
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, state IDLE, shadow registers=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE to RUN: at a clk edge with start=1, MDop in 1..4 and cancel=0.
  - MDA/MDB and MDop are latched at that edge.
  - Counter loads MUL_CYCLES or DIV_CYCLES.
  - busy rises in the following cycle, with no combinational path from start to busy.
- RUN behaviour:
  - Counter decrements each edge.
  - At the edge where the counter goes 1 to 0, HI/LO take the computed result and the state returns to IDLE.
  - busy is therefore high for exactly MUL_CYCLES or DIV_CYCLES cycles.
  - HI/LO hold their old values throughout RUN.
- The hazard unit stalls on (busy | start) whenever the instruction in D uses MDU. The MDU itself ignores start while in RUN: no relatch, no restart.
- cancel=1 in RUN: return to IDLE at the next edge, HI/LO unchanged, busy=0 the following cycle.
- cancel=1 in the same cycle as start: the start is ignored.
- mthi/mtlo (MDop 5/6):
  - Write MDA into HI/LO at the edge, with no start needed and busy never asserted.
  - Honoured only in IDLE with cancel=0; ignored in RUN.
- Arithmetic:
  - mult: {HI,LO} = signed 32x32, 64-bit product.
  - multu: {HI,LO} = unsigned 32x32 product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (MDB=0, div or divu): busy runs the normal DIV_CYCLES, HI/LO are left unchanged at completion, no trap is raised.
- Computation method (combinational on the latched operands, or iterative) is an implementation choice. The result must equal the above at the completion edge.
- HI/LO are plain register outputs; mfhi/mflo read them directly. There is no bypass of an in-flight result.

Test Plan:
- Reset with busy high mid-divide -> HI=LO=0 and busy=0 immediately, without waiting for a clk edge; next start behaves normally.
- mult, MDA=0xFFFFFFFF (-1), MDB=0x00000002 -> busy high for exactly 5 cycles starting the cycle after start; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div, MDA=0xFFFFFFF9 (-7), MDB=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, MDA=7, MDB=2 -> LO=3, HI=1.
- div with MDB=0 after a previous result HI=0x12345678 -> busy for 10 cycles, HI remains 0x12345678 and LO unchanged. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult, then pulse start with div at cycle 2 of RUN -> ignored; the mult result commits at cycle 5. mtlo 0xAAAA5555 issued during RUN -> LO unchanged. mthi 0x0000BEEF in IDLE -> HI=0x0000BEEF at the next edge, busy stays 0.
- cancel asserted at busy cycle 3 of a div -> busy=0 next cycle, HI/LO retain their pre-div values. start and cancel high in the same cycle -> busy never rises.
